// File: rtl/uart_pkg.sv
// Shared UART transmit-side definitions: sequencer state encoding and the
// ASCII line-ending bytes used by the optional CR insertion.
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_BUSY = 2'd2
   } seq_state_e;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side valid/ready byte handshake into uart_tx_fifo.
interface uart_tx_fifo_if;

   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Generic single-clock FIFO with a separate occupancy counter and synchronous flush.
module sync_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head,
   output logic [AW:0]      level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign head    = mem[rd_ptr];

   // Flush wins over any same-edge push or pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            level <= level + 1'b1;
         else if (!do_push && do_pop)
            level <= level - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus request sequencer feeding a UART transmitter.
// Optional CR-before-LF insertion is enabled by defining UART_TX_FIFO_CRLF_EN.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   uart_tx_fifo_if.slave        prod,
   input  logic                 flush,
   output logic                 uart_transmit,
   output logic [7:0]           uart_tx_byte,
   input  logic                 uart_is_transmitting,
   output logic [AW:0]          level,
   output logic                 empty,
   output logic                 full
);

   seq_state_e state;
   seq_state_e state_n;
   logic       transmit_n;
   logic [7:0] tx_byte_n;
   logic       pop;
   logic       push;
   logic [7:0] head;

   assign prod.in_ready = !full;
   assign push          = prod.in_valid && !full;

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (prod.in_data),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .level     (level),
      .full      (full),
      .empty     (empty)
   );

`ifdef UART_TX_FIFO_CRLF_EN
   logic cr_sent;
   logic cr_sent_n;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         uart_transmit <= 1'b0;
         uart_tx_byte  <= 8'h00;
`ifdef UART_TX_FIFO_CRLF_EN
         cr_sent       <= 1'b0;
`endif
      end else begin
         state         <= state_n;
         uart_transmit <= transmit_n;
         uart_tx_byte  <= tx_byte_n;
`ifdef UART_TX_FIFO_CRLF_EN
         cr_sent       <= cr_sent_n;
`endif
      end
   end

   // A new request is only issued once the UART reports idle, which also
   // covers a reset that landed in the middle of a frame.
   always_comb begin
      state_n    = state;
      transmit_n = 1'b0;
      tx_byte_n  = uart_tx_byte;
      pop        = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_sent_n  = flush ? 1'b0 : cr_sent;
`endif
      case (state)
         S_IDLE: begin
            if (!empty && !uart_is_transmitting && !flush) begin
               transmit_n = 1'b1;
               state_n    = S_REQ;
`ifdef UART_TX_FIFO_CRLF_EN
               if (head == ASCII_LF && !cr_sent) begin
                  tx_byte_n = ASCII_CR;
                  cr_sent_n = 1'b1;
               end else begin
                  pop       = 1'b1;
                  tx_byte_n = head;
                  cr_sent_n = 1'b0;
               end
`else
               pop       = 1'b1;
               tx_byte_n = head;
`endif
            end
         end
         S_REQ: begin
            transmit_n = 1'b1;
            if (uart_is_transmitting) begin
               transmit_n = 1'b0;
               state_n    = S_BUSY;
            end
         end
         S_BUSY: begin
            if (!uart_is_transmitting) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small cycle-level UART model.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       uart_transmit;
   logic [7:0] uart_tx_byte;
   logic       is_tx = 1'b0;
   logic [4:0] level;
   logic       empty;
   logic       full;

   logic       force_busy = 1'b0;
   int         frame_cnt = 0;
   logic [7:0] sent_q[$];
   logic [7:0] exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_fifo_if prod_if ();

   uart_tx_fifo #(.DEPTH(16)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .prod                 (prod_if),
      .flush                (flush),
      .uart_transmit        (uart_transmit),
      .uart_tx_byte         (uart_tx_byte),
      .uart_is_transmitting (is_tx),
      .level                (level),
      .empty                (empty),
      .full                 (full)
   );

   always #5 clk = ~clk;

   // UART model: latches the byte on a request, stays busy for a short frame
   // and only goes idle once transmit has dropped; unaffected by DUT reset.
   always @(posedge clk) begin
      if (force_busy) begin
         is_tx <= 1'b1;
      end else if (!is_tx) begin
         if (uart_transmit) begin
            is_tx     <= 1'b1;
            sent_q.push_back(uart_tx_byte);
            frame_cnt <= 3;
         end
      end else if (frame_cnt != 0) begin
         frame_cnt <= frame_cnt - 1;
      end else if (!uart_transmit) begin
         is_tx <= 1'b0;
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic add_expected(input logic [7:0] b);
`ifdef UART_TX_FIFO_CRLF_EN
      if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(b);
   endtask

   task automatic push_byte(input logic [7:0] b);
      @(negedge clk);
      prod_if.in_valid = 1'b1;
      prod_if.in_data  = b;
      @(negedge clk);
      prod_if.in_valid = 1'b0;
   endtask

   task automatic wait_sent(input int n, input int budget, output bit ok);
      int c = 0;
      while (sent_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      ok = (sent_q.size() >= n);
   endtask

   task automatic wait_quiet(input int budget, output bit ok);
      int c = 0;
      int run = 0;
      while (run < 3 && c < budget) begin
         @(negedge clk);
         c++;
         if (!is_tx && !uart_transmit && empty) run++;
         else run = 0;
      end
      ok = (run >= 3);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      prod_if.in_valid = 1'b0;
      prod_if.in_data  = 8'h00;
      repeat (3) @(negedge clk);
      n_checks++; if (uart_transmit !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_transmit: got %b expected 0", uart_transmit); end
      n_checks++; if (uart_tx_byte !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_tx_byte: got %h expected 00", uart_tx_byte); end
      n_checks++; if (level !== 5'd0) begin n_fail++; $display("[TB] FAIL rst_level: got %0d expected 0", level); end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_empty: got %b expected 1", empty); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_full: got %b expected 0", full); end
      n_checks++; if (prod_if.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %b expected 1", prod_if.in_ready); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      bit early = 1'b0;
      bit ok;
      int n = 0;
      sent_q.delete();
      @(negedge clk);
      prod_if.in_valid = 1'b1;
      prod_if.in_data  = 8'h41;
      @(negedge clk);
      prod_if.in_valid = 1'b0;
      n_checks++; if (uart_transmit !== 1'b0) begin n_fail++; $display("[TB] FAIL single_lat0: got %b expected 0", uart_transmit); end
      n_checks++; if (level !== 5'd1) begin n_fail++; $display("[TB] FAIL single_level: got %0d expected 1", level); end
      @(negedge clk);
      n_checks++; if (uart_transmit !== 1'b1) begin n_fail++; $display("[TB] FAIL single_req: got %b expected 1", uart_transmit); end
      n_checks++; if (uart_tx_byte !== 8'h41) begin n_fail++; $display("[TB] FAIL single_byte: got %h expected 41", uart_tx_byte); end
      @(negedge clk);
      n_checks++; if (uart_transmit !== 1'b1) begin n_fail++; $display("[TB] FAIL single_hold: got %b expected 1", uart_transmit); end
      @(negedge clk);
      n_checks++; if (uart_transmit !== 1'b0) begin n_fail++; $display("[TB] FAIL single_drop: got %b expected 0", uart_transmit); end
      prod_if.in_valid = 1'b1;
      prod_if.in_data  = 8'h42;
      @(negedge clk);
      prod_if.in_valid = 1'b0;
      while (is_tx && n < 50) begin
         if (uart_transmit) early = 1'b1;
         @(negedge clk);
         n++;
      end
      n_checks++; if (early !== 1'b0 || n >= 50) begin n_fail++; $display("[TB] FAIL single_no_early: got early=%b cycles=%0d expected early=0", early, n); end
      @(negedge clk);
      n_checks++; if (uart_transmit !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_gap: got %b expected 0", uart_transmit); end
      @(negedge clk);
      n_checks++; if (uart_transmit !== 1'b1 || uart_tx_byte !== 8'h42) begin n_fail++; $display("[TB] FAIL b2b_req: got %b/%h expected 1/42", uart_transmit, uart_tx_byte); end
      wait_quiet(100, ok);
      n_checks++; if (sent_q.size() != 2 || !ok) begin n_fail++; $display("[TB] FAIL single_count: got %0d expected 2", sent_q.size()); end
   endtask

   task automatic test_full();
      bit ok;
      int n = 0;
      sent_q.delete();
      exp_q.delete();
      force_busy = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         prod_if.in_valid = 1'b1;
         prod_if.in_data  = 8'(i);
         add_expected(8'(i));
         @(negedge clk);
      end
      prod_if.in_data = 8'h10;
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("[TB] FAIL full_flag: got %b expected 1", full); end
      n_checks++; if (prod_if.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ready: got %b expected 0", prod_if.in_ready); end
      n_checks++; if (level !== 5'd16) begin n_fail++; $display("[TB] FAIL full_level: got %0d expected 16", level); end
      @(negedge clk);
      n_checks++; if (level !== 5'd16) begin n_fail++; $display("[TB] FAIL full_refuse: got %0d expected 16", level); end
      force_busy = 1'b0;
      while (!uart_transmit && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_checks++; if (uart_transmit !== 1'b1 || level !== 5'd15) begin n_fail++; $display("[TB] FAIL full_pop: got req=%b level=%0d expected req=1 level=15", uart_transmit, level); end
      @(negedge clk);
      prod_if.in_valid = 1'b0;
      add_expected(8'h10);
      n_checks++; if (level !== 5'd16 || full !== 1'b1) begin n_fail++; $display("[TB] FAIL full_refill: got level=%0d full=%b expected 16/1", level, full); end
      wait_sent(exp_q.size(), 2000, ok);
      n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL full_drain: got %0d bytes expected %0d", sent_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
         n_checks++; if (sent_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL full_order[%0d]: got %h expected %h", i, sent_q[i], exp_q[i]); end
      end
      wait_quiet(200, ok);
      n_checks++; if (level !== 5'd0 || !ok) begin n_fail++; $display("[TB] FAIL full_empty: got %0d expected 0", level); end
   endtask

   task automatic test_wrap();
      bit ok;
      int idx = 0;
      int cyc = 0;
      sent_q.delete();
      exp_q.delete();
      while (idx < 40 && cyc < 3000) begin
         if (prod_if.in_ready) begin
            prod_if.in_valid = 1'b1;
            prod_if.in_data  = 8'h20 + 8'(idx);
            add_expected(8'h20 + 8'(idx));
            idx++;
         end else begin
            prod_if.in_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      prod_if.in_valid = 1'b0;
      n_checks++; if (idx != 40) begin n_fail++; $display("[TB] FAIL wrap_pushed: got %0d expected 40", idx); end
      wait_sent(40, 3000, ok);
      n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL wrap_sent: got %0d expected 40", sent_q.size()); end
      for (int i = 0; i < 40 && i < sent_q.size(); i++) begin
         n_checks++; if (sent_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", i, sent_q[i], exp_q[i]); end
      end
      wait_quiet(200, ok);
      n_checks++; if (!ok || sent_q.size() != 40) begin n_fail++; $display("[TB] FAIL wrap_quiet: got %0d bytes expected 40", sent_q.size()); end
   endtask

   task automatic test_flush();
      bit seen = 1'b0;
      int n = 0;
      logic [7:0] first;
      sent_q.delete();
      push_byte(8'h50);
      while (!is_tx && n < 20) begin
         @(negedge clk);
         n++;
      end
      force_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         prod_if.in_valid = 1'b1;
         prod_if.in_data  = 8'h51 + 8'(i);
         @(negedge clk);
      end
      prod_if.in_valid = 1'b0;
      n_checks++; if (level !== 5'd5 || uart_transmit !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_pre: got level=%0d req=%b expected 5/0", level, uart_transmit); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_checks++; if (level !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_level: got level=%0d empty=%b expected 0/1", level, empty); end
      force_busy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (uart_transmit) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_no_req: got %b expected 0", seen); end
      first = (sent_q.size() > 0) ? sent_q[0] : 8'hxx;
      n_checks++; if (sent_q.size() != 1 || first !== 8'h50 || is_tx !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_inflight: got %0d bytes first=%h expected 1 byte 50", sent_q.size(), first); end
   endtask

   task automatic test_reset_midframe();
      bit seen = 1'b0;
      bit ok;
      int n = 0;
      logic [7:0] first;
      push_byte(8'h60);
      while (!(uart_transmit && is_tx) && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_checks++; if (!(uart_transmit && is_tx)) begin n_fail++; $display("[TB] FAIL mid_setup: got req=%b busy=%b expected 1/1", uart_transmit, is_tx); end
      force_busy = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (uart_transmit !== 1'b0 || uart_tx_byte !== 8'h00) begin n_fail++; $display("[TB] FAIL mid_rst_out: got %b/%h expected 0/00", uart_transmit, uart_tx_byte); end
      n_checks++; if (level !== 5'd0 || empty !== 1'b1 || prod_if.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_rst_flags: got level=%0d empty=%b ready=%b expected 0/1/1", level, empty, prod_if.in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      sent_q.delete();
      push_byte(8'h61);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (uart_transmit) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0 || level !== 5'd1) begin n_fail++; $display("[TB] FAIL mid_wait: got req_seen=%b level=%0d expected 0/1", seen, level); end
      force_busy = 1'b0;
      n = 0;
      while (!uart_transmit && n < 30) begin
         @(negedge clk);
         n++;
      end
      n_checks++; if (uart_transmit !== 1'b1 || uart_tx_byte !== 8'h61 || is_tx !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_resume: got req=%b byte=%h expected 1/61", uart_transmit, uart_tx_byte); end
      wait_sent(1, 50, ok);
      first = (sent_q.size() > 0) ? sent_q[0] : 8'hxx;
      n_checks++; if (!ok || first !== 8'h61) begin n_fail++; $display("[TB] FAIL mid_sent: got %h expected 61", first); end
      wait_quiet(100, ok);
      n_checks++; if (!ok || sent_q.size() != 1) begin n_fail++; $display("[TB] FAIL mid_once: got %0d bytes expected 1", sent_q.size()); end
   endtask

   task automatic test_crlf();
      bit ok;
      sent_q.delete();
      exp_q.delete();
      push_byte(8'h41);
      add_expected(8'h41);
      push_byte(8'h0A);
      add_expected(8'h0A);
      wait_sent(exp_q.size(), 200, ok);
      n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL crlf_count: got %0d expected %0d", sent_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
         n_checks++; if (sent_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL crlf_byte[%0d]: got %h expected %h", i, sent_q[i], exp_q[i]); end
      end
      wait_quiet(100, ok);
      n_checks++; if (!ok || sent_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL crlf_extra: got %0d expected %0d", sent_q.size(), exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_wrap();
      test_flush();
      test_reset_midframe();
      test_crlf();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
